// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding; BAUD must match uart_tx.
package uart_pkg;
    localparam int BAUD = 12'hA2D;
    localparam int HALF = BAUD >> 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: single mid-bit sample per bit, sticky rdy, one-cycle frm_err pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CLKS = uart_pkg::BAUD,
    parameter int HALF_CLKS = BAUD_CLKS >> 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);
    localparam int CNT_W = $clog2(BAUD_CLKS);

    logic             rx_s2;
    logic             rx_prev_q, rx_prev_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q, rdy_d;
    logic             frm_err_q, frm_err_d;
    logic             tick;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s2)
    );

    assign tick = (state_q != IDLE) && (baud_cnt_q == '0);

    always_comb begin
        rx_prev_d  = rx_s2;
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = 1'b0;

        if (clr_rdy) begin
            rdy_d = 1'b0;
        end

        if (state_q != IDLE) begin
            baud_cnt_d = tick ? CNT_W'(BAUD_CLKS - 1) : baud_cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a line stuck low never retriggers.
                if (rx_prev_q && !rx_s2) begin
                    state_d    = START;
                    baud_cnt_d = CNT_W'(HALF_CLKS - 1);
                    bit_cnt_d  = '0;
                    rdy_d      = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rx_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s2) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_prev_q  <= rx_prev_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: the bench drives the serial line with uart_tx frame timing.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int B   = 260;
    localparam int H   = B >> 1;
    localparam int LAT = H + 9 * B + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int n_cmp = 0;
    int n_err = 0;

    int rdy_at, rdy_cnt, fe_cnt;
    logic [7:0] snap_data;
    logic       snap_rdy, snap_fe;
    logic [1:0] snap_state;

    uart_rx #(.BAUD_CLKS(B), .HALF_CLKS(H)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: start, 8 data bits LSB first, stop level held for stop_cyc cycles.
    // Cycle k+1 is the number of rising edges since rx was driven low.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cyc,
                              input int rst_at, output int r_at, output int r_cnt,
                              output int f_cnt);
        r_at  = -1;
        r_cnt = 0;
        f_cnt = 0;
        for (int k = 0; k < 9 * B + stop_cyc; k++) begin
            if (k < B)          rx = 1'b0;
            else if (k < 9 * B) rx = b[(k - B) / B];
            else                rx = stop_v;
            if (rst_at >= 0) rst_n = !(k == rst_at || k == rst_at + 1);
            step(1);
            if (k == rst_at) begin
                snap_data  = rx_data;
                snap_rdy   = rdy;
                snap_fe    = frm_err;
                snap_state = dut.state_q;
            end
            if (k + 1 > 3 && rdy === 1'b1) begin
                if (r_at < 0) r_at = k + 1;
                r_cnt++;
            end
            if (frm_err === 1'b1) f_cnt++;
        end
        rx    = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr(input string tag);
        chk({tag, "_rdy_set"}, 32'(rdy), 32'd1);
        clr_rdy = 1'b1;
        step(1);
        chk({tag, "_rdy_clr"}, 32'(rdy), 32'd0);
        clr_rdy = 1'b0;
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_fe", 32'(frm_err), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        step(5);

        // Back-to-back A5 then 3C
        send_frame(8'hA5, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("a5_lat_ok", 32'(rdy_at >= LAT - 1 && rdy_at <= LAT + 1), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_fe", 32'(fe_cnt), 32'd0);
        send_frame(8'h3C, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("3c_lat_ok", 32'(rdy_at >= LAT - 1 && rdy_at <= LAT + 1), 32'd1);
        chk("3c_data", 32'(rx_data), 32'h3C);
        chk("3c_fe", 32'(fe_cnt), 32'd0);

        // Boundary bytes with host acknowledge
        send_frame(8'h00, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("00_data", 32'(rx_data), 32'h00);
        pulse_clr("00");
        step(10);
        send_frame(8'hFF, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("ff_data", 32'(rx_data), 32'hFF);
        pulse_clr("ff");
        step(10);

        // Glitch shorter than half a bit: false start aborts at the first tick
        rx = 1'b0;
        step(100);
        rx = 1'b1;
        step(32);
        chk("glitch_start", 32'(dut.state_q), 32'(START));
        step(1);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        step(B);
        chk("glitch_rdy", 32'(rdy), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'hFF);
        send_frame(8'h5A, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("5a_data", 32'(rx_data), 32'h5A);
        chk("5a_lat", 32'(rdy_at), 32'(LAT));
        pulse_clr("5a");
        step(10);

        // Framing error: stop bit low for two bit times
        send_frame(8'hC3, 1'b0, 2 * B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("c3_fe_cycles", 32'(fe_cnt), 32'd1);
        chk("c3_rdy_cycles", 32'(rdy_cnt), 32'd0);
        chk("c3_data_kept", 32'(rx_data), 32'h5A);
        step(B);
        send_frame(8'h81, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("81_data", 32'(rx_data), 32'h81);
        chk("81_fe", 32'(fe_cnt), 32'd0);
        pulse_clr("81");
        step(10);

        // Set and clear in the same cycle: set wins for one cycle
        clr_rdy = 1'b1;
        send_frame(8'h7E, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        clr_rdy = 1'b0;
        chk("7e_rdy_cycles", 32'(rdy_cnt), 32'd1);
        chk("7e_lat", 32'(rdy_at), 32'(LAT));
        chk("7e_data", 32'(rx_data), 32'h7E);
        step(10);

        // Reset in the middle of data bit 4 of F0
        send_frame(8'hF0, 1'b1, B, 5 * B + B / 2, rdy_at, rdy_cnt, fe_cnt);
        chk("mrst_data", 32'(snap_data), 32'h00);
        chk("mrst_rdy", 32'(snap_rdy), 32'd0);
        chk("mrst_fe", 32'(snap_fe), 32'd0);
        chk("mrst_state", 32'(snap_state), 32'(IDLE));
        chk("f0_rdy_cycles", 32'(rdy_cnt), 32'd0);
        chk("f0_fe_cycles", 32'(fe_cnt), 32'd0);
        step(B);
        chk("f0_data_reset", 32'(rx_data), 32'h00);
        send_frame(8'h0F, 1'b1, B, -1, rdy_at, rdy_cnt, fe_cnt);
        chk("0f_data", 32'(rx_data), 32'h0F);
        chk("0f_lat", 32'(rdy_at), 32'(LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the serial line driven by uart_tx and recovers bytes.
- Frame format: 8N1, LSB first, 1 start bit (0), 8 data bits, 1 stop bit (1).
- Bit period: BAUD clocks, the same constant uart_tx uses.
- Output: a byte plus a sticky ready flag. The host side reads the byte and clears the flag.
- Sits directly downstream of uart_tx on the link and serves as its loopback checker in system benches.

Parameters:
- BAUD, 12'hA2D (2605), clocks per bit; must match uart_tx.
- HALF, BAUD>>1 (1302), clocks from start-edge detection to the mid-start-bit sample.

Ports:
- clk      input   1  system clock, rising edge
- rst_n    input   1  synchronous active-low reset
- rx       input   1  asynchronous serial line, idle high
- clr_rdy  input   1  host acknowledge; clears rdy
- rx_data  output  8  last correctly framed byte
- rdy      output  1  sticky; byte available in rx_data
- frm_err  output  1  one-cycle pulse; stop bit sampled as 0

Behaviour:
- Reset: clock and reset ports are clk and rst_n. Reset is synchronous and active-low (sampled on the clk rising edge).
- Values held during reset: rx_data=8'h00, rdy=0, frm_err=0, state=IDLE, sync flops=1, baud_cnt=0, bit_cnt=0.
- Synchronizer: rx passes through two flops (rx_s1, rx_s2), then one more flop rx_prev for edge detection. All internal logic uses rx_s2 only.
- Start detect: in IDLE, when rx_prev=1 and rx_s2=0:
  - go to START;
  - load baud_cnt=HALF-1;
  - clear bit_cnt;
  - clear rdy (a new frame overrides an unread byte).
- Baud counter: decrements every cycle outside IDLE. A "tick" occurs in the cycle baud_cnt==0; on each tick the counter reloads BAUD-1.
- START state, on tick:
  - rx_s2=0 -> go to DATA;
  - rx_s2=1 -> false start (glitch); return to IDLE, no outputs change.
- DATA state, on each tick:
  - shift rx_s2 into shift[7] of an 8-bit shift register (right shift, LSB first);
  - bit_cnt++;
  - after the 8th data tick (bit_cnt==8), go to STOP.
- STOP state, on tick:
  - rx_s2=1 -> rx_data<=shift, rdy<=1 in the same edge;
  - rx_s2=0 -> rx_data unchanged, rdy unchanged, frm_err=1 for exactly one cycle.
  - Either way return to IDLE.
  - A line held low after a framing error is not a new start: a 1->0 edge is required.
- Latency: rdy rises HALF + 9*BAUD + 3 cycles (sync plus edge flop) after the rx falling edge. That is about 9.5 bit times, before the stop bit ends, so back-to-back frames from uart_tx are never missed.
- rdy clearing:
  - cleared by clr_rdy=1 on any edge, or by a start detect;
  - if set (stop tick) and clear occur in the same cycle, set wins.
- rx_data: stable between stop ticks. It is never updated by a framing-error frame.
- Reset mid-frame: asserting rst_n=0 aborts immediately to reset values. A frame already in progress when rst_n deasserts is ignored until the next 1->0 edge. The sync flops reset to 1, so no false start is generated.
- No parity and no oversampling/majority vote: there is a single sample per bit at mid-bit.

Decomposition:
- Package uart_pkg:
  - BAUD and HALF localparams, shared with uart_tx;
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t.
- One sub-module: sync2 (2-flop synchronizer, parameterised reset value, reset value 1 here). It is reusable for other async inputs.
- Everything else (baud counter, bit counter, shift register, FSM) stays flat in uart_rx.

Test Plan:
1. Loopback via uart_tx: send 8'hA5, then 8'h3C back-to-back (next tx_start on tx_rdy).
   - rdy rises within HALF+9*BAUD+3 ±1 cycles of each start edge;
   - rx_data=A5, then 3C;
   - frm_err never asserted.
2. Boundary bytes 8'h00 and 8'hFF, with clr_rdy pulsed after each rdy.
   - rx_data matches each byte;
   - rdy goes 0 the cycle after clr_rdy.
3. Glitch: drive rx low for 100 cycles, then high.
   - state returns to IDLE at the first tick;
   - rdy stays 0 and rx_data is unchanged;
   - a following valid 8'h5A frame is received correctly.
4. Framing error: hand-drive frame 8'hC3 with the stop bit held 0 for 2*BAUD, then high.
   - frm_err high exactly one cycle;
   - rdy stays 0 and rx_data keeps its previous value;
   - a subsequent 8'h81 frame is received.
5. Set/clear collision: hold clr_rdy=1 continuously across the stop tick of frame 8'h7E.
   - rdy high for exactly one cycle, then 0;
   - rx_data=7E.
6. Reset mid-frame: assert rst_n=0 for 2 cycles during data bit 4 of 8'hF0.
   - all outputs equal reset values;
   - the remainder of that frame produces no rdy and no frm_err;
   - the next 8'h0F frame is received correctly.
